bsg_mem_1rw_sync_mask_write_bit_rmw: RTL



---
 rtl/bsg_mem_1rw_sync_mask_write_bit_rmw.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_rmw.sv
// Banked 1RW synchronous memory with per-bit write mask, built on full-word
// storage: partial-mask writes go through a two-cycle read-modify-write.
module bsg_mem_1rw_sync_mask_write_bit_rmw #(
  parameter int width_p           = 64,
  parameter int els_p             = 256,
  parameter int num_banks_p       = 2,
  parameter int latch_last_read_p = 1,
  parameter int addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o
);

  localparam int lg_banks_lp = (num_banks_p > 1) ? $clog2(num_banks_p) : 0;
  localparam int bank_w_lp   = (lg_banks_lp > 0) ? lg_banks_lp : 1;
  localparam int rows_lp     = els_p / num_banks_p;
  localparam int row_w_lp    = (addr_width_lp > lg_banks_lp) ? addr_width_lp - lg_banks_lp : 1;

  localparam logic state_idle  = 1'b0;
  localparam logic state_merge = 1'b1;

  if ((els_p % num_banks_p) != 0) begin : g_bad_els
    $error("els_p (%0d) must be a multiple of num_banks_p (%0d)", els_p, num_banks_p);
  end
  if ((num_banks_p < 1) || ((num_banks_p & (num_banks_p - 1)) != 0)) begin : g_bad_banks
    $error("num_banks_p (%0d) must be a power of two", num_banks_p);
  end
  if (width_p >= 1) begin : g_cfg
    $info("bsg_mem_1rw_sync_mask_write_bit_rmw: width_p=%0d els_p=%0d num_banks_p=%0d",
          width_p, els_p, num_banks_p);
  end

  logic                     state_q, state_d;
  logic                     v_o_q, v_o_d;
  logic [addr_width_lp-1:0] addr_q, addr_d;
  logic [width_p-1:0]       data_q, data_d;
  logic [width_p-1:0]       mask_q, mask_d;
  logic [width_p-1:0]       last_q, last_d;
  logic [width_p-1:0]       rd_word_q;

  logic                     accept;
  logic                     arr_re, arr_we;
  logic [addr_width_lp-1:0] arr_addr;
  logic [bank_w_lp-1:0]     arr_bank;
  logic [row_w_lp-1:0]      arr_row;
  logic [width_p-1:0]       arr_wdata;

  logic [width_p-1:0] mem_q [num_banks_p][rows_lp];

  assign ready_o = (state_q == state_idle) && reset_n_i;
  assign accept  = ready_o && v_i;

  // Low address bits select the bank, the rest select the row within it.
  if (lg_banks_lp == 0) begin : g_one_bank
    assign arr_bank = '0;
    assign arr_row  = arr_addr;
  end else if (addr_width_lp > lg_banks_lp) begin : g_banked
    assign arr_bank = arr_addr[lg_banks_lp-1:0];
    assign arr_row  = arr_addr[addr_width_lp-1:lg_banks_lp];
  end else begin : g_one_row
    assign arr_bank = arr_addr[lg_banks_lp-1:0];
    assign arr_row  = '0;
  end

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    v_o_d     = 1'b0;
    arr_re    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = addr_i;
    arr_wdata = data_i;
    last_d    = v_o_q ? rd_word_q : last_q;

    if (state_q == state_merge) begin
      // Old word arrived from the acceptance-cycle read; reset aborts the write.
      arr_addr  = addr_q;
      arr_wdata = (rd_word_q & ~mask_q) | (data_q & mask_q);
      arr_we    = reset_n_i;
      state_d   = state_idle;
    end else if (accept) begin
      if (!w_i) begin
        arr_re = 1'b1;
        v_o_d  = 1'b1;
      end else if (&w_mask_i) begin
        arr_we = 1'b1;
      end else if (|w_mask_i) begin
        arr_re  = 1'b1;
        addr_d  = addr_i;
        data_d  = data_i;
        mask_d  = w_mask_i;
        state_d = state_merge;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= state_idle;
      v_o_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      v_o_q   <= v_o_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
    end
  end

  // NOTE: the array and its read register are deliberately not reset, like a real macro.
  always_ff @(posedge clk_i) begin
    if (arr_we) mem_q[arr_bank][arr_row] <= arr_wdata;
    if (arr_re) rd_word_q <= mem_q[arr_bank][arr_row];
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      assert (int'(addr_i) < els_p)
        else $error("address %0d out of range (els_p=%0d)", addr_i, els_p);
    end
  end

  assign v_o    = v_o_q;
  assign data_o = v_o_q ? rd_word_q : ((latch_last_read_p != 0) ? last_q : '0);

endmodule
